// File: rtl/chess_pkg.sv
// Chess square encoding shared by the board consumers: piece codes, colour bit,
// ASCII helpers and the state encodings of the board UART dump.
package chess_pkg;

  localparam logic [2:0] PIECE_EMPTY   = 3'd0;
  localparam logic [2:0] PIECE_PAWN    = 3'd1;
  localparam logic [2:0] PIECE_KNIGHT  = 3'd2;
  localparam logic [2:0] PIECE_BISHOP  = 3'd3;
  localparam logic [2:0] PIECE_ROOK    = 3'd4;
  localparam logic [2:0] PIECE_QUEEN   = 3'd5;
  localparam logic [2:0] PIECE_KING    = 3'd6;
  localparam logic [2:0] PIECE_INVALID = 3'd7;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {FR_IDLE, FR_LOAD, FR_SEND, FR_DONE} frame_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // White pieces are uppercase, black lowercase; '.' and '?' carry no colour.
  function automatic logic [7:0] piece_to_ascii(input logic [3:0] sq);
    logic [7:0] c;
    logic       lower;
    case (sq[2:0])
      PIECE_EMPTY:  c = 8'h2E;
      PIECE_PAWN:   c = 8'h50;
      PIECE_KNIGHT: c = 8'h4E;
      PIECE_BISHOP: c = 8'h42;
      PIECE_ROOK:   c = 8'h52;
      PIECE_QUEEN:  c = 8'h51;
      PIECE_KING:   c = 8'h4B;
      default:      c = 8'h3F;
    endcase
    case (sq[3])
      COLOR_WHITE: lower = 1'b0;
      COLOR_BLACK: lower = (sq[2:0] != PIECE_EMPTY) && (sq[2:0] != PIECE_INVALID);
      default:     lower = 1'b0;
    endcase
    return lower ? (c | 8'h20) : c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, CLKS_PER_BIT clocks per bit, line idles high.
// o_rdy also rises in the last stop-bit cycle so a byte offered then follows with no gap.
module uart_tx_byte
  import chess_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       full_clock,
  input  logic       Reset,
  input  logic       i_vld,
  input  logic [7:0] i_dat,
  output logic       o_rdy,
  output logic       o_tx
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     r_state;
  tx_state_t     w_state_nxt;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [9:0]    r_shift;
  logic          w_bit_end;
  logic          w_accept;

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign o_rdy     = (r_state == TX_IDLE) || ((r_state == TX_STOP) && w_bit_end);
  assign w_accept  = i_vld && o_rdy;
  assign o_tx      = r_shift[0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TX_IDLE:  if (w_accept) w_state_nxt = TX_START;
      TX_START: if (w_bit_end) w_state_nxt = TX_DATA;
      TX_DATA:  if (w_bit_end && (r_bit == 3'd7)) w_state_nxt = TX_STOP;
      TX_STOP:  if (w_bit_end) w_state_nxt = w_accept ? TX_START : TX_IDLE;
      default:  w_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) r_state <= TX_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Shifter holds {stop, data, start}; ones shift in so the line rests high.
  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '1;
    end else begin
      if ((r_state == TX_IDLE) || w_bit_end) r_baud <= '0;
      else                                   r_baud <= r_baud + 1'b1;
      if ((r_state == TX_DATA) && w_bit_end) r_bit <= r_bit + 3'd1;
      if (w_accept)                                  r_shift <= {1'b1, i_dat, 1'b0};
      else if ((r_state != TX_IDLE) && w_bit_end)    r_shift <= {1'b1, r_shift[9:1]};
    end
  end

endmodule

// File: rtl/board_uart_dump.sv
// Snapshots the 64-square board on each dump_req rising edge and sends it as
// eight 8-character ASCII rows, each ended by CR LF (80 bytes, 8N1) on uart_tx.
module board_uart_dump
  import chess_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic         full_clock,
  input  logic         Reset,
  input  logic [255:0] board,
  input  logic         dump_req,
  output logic         uart_tx,
  output logic         busy,
  output logic         frame_done
);

  localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [6:0] LAST_BYTE    = 7'd79;

  frame_state_t r_state;
  frame_state_t w_state_nxt;
  logic         r_req_s1;
  logic         r_req_s2;
  logic         r_req_d;
  logic         w_req_edge;
  logic         r_pend;
  logic [255:0] r_snap;
  logic [6:0]   r_idx;
  logic [2:0]   r_row;
  logic [3:0]   r_col;
  logic [255:0] w_src;
  logic [2:0]   w_row;
  logic [3:0]   w_col;
  logic [3:0]   w_sq_code;
  logic [7:0]   w_char;
  logic         w_last;
  logic         w_tx_vld;
  logic         w_tx_rdy;

  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      r_req_s1 <= 1'b0;
      r_req_s2 <= 1'b0;
      r_req_d  <= 1'b0;
    end else begin
      r_req_s1 <= dump_req;
      r_req_s2 <= r_req_s1;
      r_req_d  <= r_req_s2;
    end
  end

  assign w_req_edge = r_req_s2 & ~r_req_d;
  assign w_last     = (r_idx == LAST_BYTE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FR_IDLE: if (w_req_edge) w_state_nxt = FR_LOAD;
      FR_LOAD: w_state_nxt = FR_SEND;
      FR_SEND: if (w_tx_rdy && w_last) w_state_nxt = FR_DONE;
      FR_DONE: w_state_nxt = (r_pend || w_req_edge) ? FR_LOAD : FR_IDLE;
      default: w_state_nxt = FR_IDLE;
    endcase
  end

  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) r_state <= FR_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Requests arriving mid-frame collapse into one follow-on frame.
  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset)                                      r_pend <= 1'b0;
    else if (r_state == FR_DONE)                    r_pend <= 1'b0;
    else if (w_req_edge && (r_state != FR_IDLE))    r_pend <= 1'b1;
  end

  // (r_row, r_col) points at the byte offered next; r_idx is the byte in flight.
  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      r_snap <= '0;
      r_idx  <= '0;
      r_row  <= '0;
      r_col  <= '0;
    end else if (r_state == FR_LOAD) begin
      r_snap <= board;
      r_idx  <= '0;
      r_row  <= '0;
      r_col  <= 4'd1;
    end else if ((r_state == FR_SEND) && w_tx_vld && w_tx_rdy) begin
      r_idx <= r_idx + 7'd1;
      if (r_col == 4'd9) begin
        r_col <= '0;
        r_row <= r_row + 3'd1;
      end else begin
        r_col <= r_col + 4'd1;
      end
    end
  end

  // Byte 0 leaves during LOAD, so it reads the live board being captured that same edge.
  assign w_src     = (r_state == FR_LOAD) ? board : r_snap;
  assign w_row     = (r_state == FR_LOAD) ? 3'd0 : r_row;
  assign w_col     = (r_state == FR_LOAD) ? 4'd0 : r_col;
  assign w_sq_code = w_src[{w_row, w_col[2:0], 2'b00} +: 4];

  always_comb begin
    w_char = piece_to_ascii(w_sq_code);
    if (w_col[3]) w_char = w_col[0] ? ASCII_LF : ASCII_CR;
  end

  assign w_tx_vld   = (r_state == FR_LOAD) || ((r_state == FR_SEND) && !w_last);
  assign busy       = (r_state == FR_LOAD) || (r_state == FR_SEND);
  assign frame_done = (r_state == FR_DONE);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .full_clock(full_clock),
    .Reset     (Reset),
    .i_vld     (w_tx_vld),
    .i_dat     (w_char),
    .o_rdy     (w_tx_rdy),
    .o_tx      (uart_tx)
  );

endmodule

// File: tb/tb_board_uart_dump.sv
// Directed bench for board_uart_dump at 10 clocks per bit: decodes frames off the
// serial line and compares them with hand-written row strings.
module tb_board_uart_dump;

  logic         full_clock = 1'b0;
  logic         Reset      = 1'b1;
  logic [255:0] board      = '0;
  logic         dump_req   = 1'b0;
  logic         uart_tx;
  logic         busy;
  logic         frame_done;

  int          total    = 0;
  int          bad      = 0;
  int          done_cnt = 0;
  logic [7:0]  got [80];
  string       exp_rows [8];

  board_uart_dump #(
    .CLK_HZ(1000),
    .BAUD  (100)
  ) dut (
    .full_clock(full_clock),
    .Reset     (Reset),
    .board     (board),
    .dump_req  (dump_req),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 full_clock = ~full_clock;

  always @(negedge full_clock) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [255:0] init_board();
    logic [3:0]   back [8];
    logic [255:0] b;
    back = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[4*c +: 4]      = back[c] | 4'h8;
      b[4*(8+c) +: 4]  = 4'h9;
      b[4*(48+c) +: 4] = 4'h1;
      b[4*(56+c) +: 4] = back[c];
    end
    return b;
  endfunction

  task automatic set_init_rows();
    exp_rows[0] = "rnbqkbnr";
    exp_rows[1] = "pppppppp";
    for (int r = 2; r < 6; r++) exp_rows[r] = "........";
    exp_rows[6] = "PPPPPPPP";
    exp_rows[7] = "RNBQKBNR";
  endtask

  function automatic logic [7:0] exp_at(input int idx);
    string s;
    int    c;
    c = idx % 10;
    if (c == 8) return 8'h0D;
    if (c == 9) return 8'h0A;
    s = exp_rows[idx / 10];
    return s[c];
  endfunction

  task automatic pulse_req();
    @(negedge full_clock);
    dump_req = 1'b1;
    repeat (4) @(negedge full_clock);
    dump_req = 1'b0;
  endtask

  // Samples each bit mid-cell; returns positioned halfway into the stop bit.
  task automatic rx_byte(output logic [7:0] b, output logic err);
    int n;
    n = 0;
    b = 8'h00;
    err = 1'b0;
    while ((uart_tx !== 1'b0) && (n < 3000)) begin
      @(negedge full_clock);
      n++;
    end
    if (uart_tx !== 1'b0) begin
      err = 1'b1;
      return;
    end
    repeat (5) @(negedge full_clock);
    if (uart_tx !== 1'b0) err = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge full_clock);
      b[i] = uart_tx;
    end
    repeat (10) @(negedge full_clock);
    if (uart_tx !== 1'b1) err = 1'b1;
  endtask

  task automatic rx_frame(output logic err);
    logic [7:0] b;
    logic       e;
    err = 1'b0;
    for (int i = 0; i < 80; i++) begin
      rx_byte(b, e);
      got[i] = b;
      if (e) begin
        err = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(output logic seen);
    int n;
    n = 0;
    while ((frame_done !== 1'b1) && (n < 200)) begin
      @(negedge full_clock);
      n++;
    end
    seen = (frame_done === 1'b1);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge full_clock);
    total++;
    if ({uart_tx, busy, frame_done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_hold: tx/busy/done=%b required 100", {uart_tx, busy, frame_done});
    end
    Reset = 1'b0;
    repeat (5) @(negedge full_clock);
    total++;
    if ({uart_tx, busy, frame_done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_idle: tx/busy/done=%b required 100", {uart_tx, busy, frame_done});
    end
  endtask

  task automatic test_frame_basic();
    logic err, seen;
    int   base;
    board = init_board();
    set_init_rows();
    base = done_cnt;
    pulse_req();
    rx_frame(err);
    total++;
    if (err) begin
      bad++;
      $display("FAIL basic_rx: framing error or timeout, required 80 clean bytes");
    end
    for (int i = 0; i < 80; i++) begin
      total++;
      if (got[i] !== exp_at(i)) begin
        bad++;
        $display("FAIL basic_byte%0d: got %h required %h", i, got[i], exp_at(i));
      end
    end
    wait_done(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL basic_done: frame_done never seen, required one pulse");
    end
    repeat (20) @(negedge full_clock);
    total++;
    if ((done_cnt - base) !== 1) begin
      bad++;
      $display("FAIL basic_done_count: got %0d pulses required 1", done_cnt - base);
    end
  endtask

  task automatic test_bit_timing();
    logic slot_bit [10];
    logic ok;
    slot_bit = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    board = init_board();
    @(negedge full_clock);
    dump_req = 1'b1;
    repeat (2) @(negedge full_clock);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL timing_busy_early: busy=%b required 0 before snapshot", busy);
    end
    @(negedge full_clock);
    total++;
    if ({busy, uart_tx} !== 2'b11) begin
      bad++;
      $display("FAIL timing_load: busy/tx=%b required 11 in snapshot cycle", {busy, uart_tx});
    end
    dump_req = 1'b0;
    for (int s = 0; s < 10; s++) begin
      ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge full_clock);
        if (uart_tx !== slot_bit[s]) ok = 1'b0;
      end
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL timing_slot%0d: line not held at %b for 10 clocks", s, slot_bit[s]);
      end
    end
    @(negedge full_clock);
    total++;
    if (uart_tx !== 1'b0) begin
      bad++;
      $display("FAIL timing_b2b: tx=%b required 0 (next start bit, no gap)", uart_tx);
    end
    ok = 1'b1;
    for (int k = 105; k <= 8003; k++) begin
      @(negedge full_clock);
      if (busy !== 1'b1) ok = 1'b0;
    end
    total++;
    if (!ok || (frame_done !== 1'b0) || (uart_tx !== 1'b1)) begin
      bad++;
      $display("FAIL timing_busy_span: busy_ok=%b done=%b tx=%b required 1 0 1", ok, frame_done, uart_tx);
    end
    @(negedge full_clock);
    total++;
    if ({frame_done, busy, uart_tx} !== 3'b101) begin
      bad++;
      $display("FAIL timing_done: done/busy/tx=%b required 101 at 8000 clk", {frame_done, busy, uart_tx});
    end
    @(negedge full_clock);
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL timing_done_width: done=%b required 0 after 1 cycle", frame_done);
    end
    repeat (10) @(negedge full_clock);
  endtask

  task automatic test_pending();
    logic err, seen;
    int   base;
    board = init_board();
    set_init_rows();
    base = done_cnt;
    pulse_req();
    fork
      rx_frame(err);
      begin
        repeat (500) @(negedge full_clock);
        board[4*12 +: 4] = 4'b0000;
        repeat (500) @(negedge full_clock);
        pulse_req();
        repeat (1500) @(negedge full_clock);
        pulse_req();
      end
    join
    total++;
    if (err) begin
      bad++;
      $display("FAIL pend_rx_a: framing error or timeout in first frame");
    end
    for (int i = 0; i < 80; i++) begin
      total++;
      if (got[i] !== exp_at(i)) begin
        bad++;
        $display("FAIL pend_a_byte%0d: got %h required %h", i, got[i], exp_at(i));
      end
    end
    wait_done(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL pend_done_a: frame_done never seen for first frame");
    end
    @(negedge full_clock);
    total++;
    if ({busy, uart_tx} !== 2'b11) begin
      bad++;
      $display("FAIL pend_reload: busy/tx=%b required 11 right after frame_done", {busy, uart_tx});
    end
    @(negedge full_clock);
    total++;
    if (uart_tx !== 1'b0) begin
      bad++;
      $display("FAIL pend_start: tx=%b required 0 two clocks after frame_done", uart_tx);
    end
    exp_rows[1] = "pppp.ppp";
    rx_frame(err);
    total++;
    if (err) begin
      bad++;
      $display("FAIL pend_rx_b: framing error or timeout in follow-on frame");
    end
    for (int i = 0; i < 80; i++) begin
      total++;
      if (got[i] !== exp_at(i)) begin
        bad++;
        $display("FAIL pend_b_byte%0d: got %h required %h", i, got[i], exp_at(i));
      end
    end
    wait_done(seen);
    repeat (300) @(negedge full_clock);
    total++;
    if (((done_cnt - base) !== 2) || (busy !== 1'b0)) begin
      bad++;
      $display("FAIL pend_count: frames=%0d busy=%b required 2 and 0", done_cnt - base, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic err, seen, ok;
    int   base;
    board = init_board();
    set_init_rows();
    base = done_cnt;
    @(negedge full_clock);
    dump_req = 1'b1;
    repeat (4) @(negedge full_clock);
    dump_req = 1'b0;
    repeat (100) @(negedge full_clock);
    dump_req = 1'b1;
    repeat (5) @(negedge full_clock);
    dump_req = 1'b0;
    repeat (230) @(negedge full_clock);
    total++;
    if (uart_tx !== 1'b0) begin
      bad++;
      $display("FAIL rst_pre: tx=%b required 0 ('q' bit d2 of byte 3)", uart_tx);
    end
    #1 Reset = 1'b1;
    #1;
    total++;
    if ({uart_tx, busy, frame_done} !== 3'b100) begin
      bad++;
      $display("FAIL rst_async: tx/busy/done=%b required 100 same cycle", {uart_tx, busy, frame_done});
    end
    repeat (2) @(negedge full_clock);
    Reset = 1'b0;
    ok = 1'b1;
    repeat (300) begin
      @(negedge full_clock);
      if ((busy !== 1'b0) || (uart_tx !== 1'b1)) ok = 1'b0;
    end
    total++;
    if (!ok || (done_cnt !== base)) begin
      bad++;
      $display("FAIL rst_no_stale: idle_ok=%b frames=%0d required 1 and 0", ok, done_cnt - base);
    end
    pulse_req();
    rx_frame(err);
    total++;
    if (err) begin
      bad++;
      $display("FAIL rst_rx: framing error or timeout after reset");
    end
    for (int i = 0; i < 80; i++) begin
      total++;
      if (got[i] !== exp_at(i)) begin
        bad++;
        $display("FAIL rst_byte%0d: got %h required %h", i, got[i], exp_at(i));
      end
    end
    wait_done(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL rst_done: frame_done never seen after reset");
    end
    repeat (10) @(negedge full_clock);
  endtask

  task automatic test_codes();
    logic err, seen;
    board = init_board();
    board[4*16 +: 4] = 4'b1000;
    board[4*17 +: 4] = 4'b0111;
    board[4*18 +: 4] = 4'b1101;
    board[4*19 +: 4] = 4'b0010;
    set_init_rows();
    exp_rows[2] = ".?qN....";
    pulse_req();
    rx_frame(err);
    total++;
    if (err) begin
      bad++;
      $display("FAIL codes_rx: framing error or timeout");
    end
    for (int i = 0; i < 80; i++) begin
      total++;
      if (got[i] !== exp_at(i)) begin
        bad++;
        $display("FAIL codes_byte%0d: got %h required %h", i, got[i], exp_at(i));
      end
    end
    wait_done(seen);
    repeat (10) @(negedge full_clock);
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_bit_timing();
    test_pending();
    test_reset_mid();
    test_codes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
